mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Merges the core's instruction and data memory request ports (req/gnt/valid protocol) onto a single memory port feeding one cip_axi_from_mem converter.
- Lets a socket expose one AXI master instead of two.
- Arbitrates requests (round-robin or fixed priority) and tracks up to MAX_OUTSTANDING in-flight transactions in an ID FIFO.
- Routes in-order responses back to the issuing port.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports; be width = DATA_WIDTH/8
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (power of 2, >=1)
- FIXED_PRIO, 0, 0 = round-robin; 1 = data port (port 1) always wins

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- s0_req_i  in  1  instruction port request (read-only requester)
- s0_addr_i  in  ADDR_WIDTH  instruction address
- s0_gnt_o  out  1  instruction request accepted
- s0_valid_o  out  1  instruction response valid
- s0_rdata_o  out  DATA_WIDTH  instruction read data
- s0_error_o  out  1  instruction response error
- s1_req_i  in  1  data port request
- s1_addr_i  in  ADDR_WIDTH  data address
- s1_we_i  in  1  data write enable
- s1_wdata_i  in  DATA_WIDTH  write data
- s1_be_i  in  DATA_WIDTH/8  byte enables
- s1_gnt_o  out  1  data request accepted
- s1_valid_o  out  1  data response valid
- s1_rdata_o  out  DATA_WIDTH  data read data
- s1_error_o  out  1  data response error
- m_req_o  out  1  merged request
- m_addr_o  out  ADDR_WIDTH  merged address
- m_we_o  out  1  merged write enable (0 when port 0 selected)
- m_wdata_o  out  DATA_WIDTH  merged write data (0 when port 0 selected)
- m_be_o  out  DATA_WIDTH/8  merged byte enables (0 when port 0 selected)
- m_gnt_i  in  1  downstream accept
- m_valid_i  in  1  downstream response valid
- m_rdata_i  in  DATA_WIDTH  downstream read data
- m_error_i  in  1  downstream response error
- spurious_o  out  1  sticky flag: response received with no outstanding transaction

Behaviour:
- Reset (rst_ni low at posedge): ID FIFO empty, lock cleared, round-robin pointer favours port 0, spurious_o=0. All outputs are combinational from state/inputs; with no requests, every output is 0.
- Handshake:
  - A transfer occurs on a cycle with req && gnt.
  - Requesters hold req and payload stable until gnt.
  - Responses return in issue order, one per m_valid_i cycle.
- full = (FIFO count == MAX_OUTSTANDING).
- m_req_o = (s0_req_i | s1_req_i) & ~full. A pop in the same cycle does not unblock a full FIFO; the request issues next cycle at the earliest.
- Selection (sel):
  - If lock is set, sel = locked_id.
  - Else, with one requester, sel = that requester.
  - Else, with both requesting: FIXED_PRIO=1 gives sel=1; otherwise sel = rr pointer.
- m_addr/we/wdata/be are muxed from sel.
- sN_gnt_o = m_gnt_i & m_req_o & (sel==N). Zero latency: gnt passes combinationally.
- Lock: if m_req_o && !m_gnt_i, register lock=1 and locked_id=sel. Clear the lock on the accepting cycle. The selection never switches while a request is stalled.
- Round-robin: on each accept of port N, the pointer moves to the other port.
- On accept, push sel into the ID FIFO (1-bit entries, wrap-around read/write pointers, count 0..MAX_OUTSTANDING).
- On m_valid_i with FIFO non-empty:
  - Pop the FIFO.
  - Set s[head]_valid_o = 1 and s[head]_error_o = m_error_i; the other port sees valid=0, error=0.
  - m_rdata_i is broadcast to both rdata outputs.
- Same-cycle response: the response can arrive in the same cycle as the accept only if the FIFO was non-empty. The popped head is the older entry. Push and pop in the same cycle keep count unchanged.
- On m_valid_i with FIFO empty: no sN_valid_o, set spurious_o (sticky until reset), FIFO unchanged.
- Reset mid-operation: all outstanding IDs are discarded. The downstream converter and core share rst_ni and must be reset together.

Test Plan:
- Only s0 requests addr 0x0000_0100, m_gnt_i=1, response 0xDEADBEEF two cycles later -> s0_gnt_o pulses in cycle 0; s0_valid_o=1 with rdata 0xDEADBEEF; s1_valid_o stays 0; m_we_o=0.
- s0 and s1 both request each cycle, FIXED_PRIO=0, m_gnt_i=1, responses 1 cycle later -> grants alternate 0,1,0,1 starting with port 0 after reset; each response is routed to the matching port in order.
- Both requesting, FIXED_PRIO=1 -> s1 granted every cycle, s0_gnt_o never asserted while s1_req_i=1.
- s0 wins with m_gnt_i=0 for 3 cycles, then s1 raises req, then m_gnt_i=1 -> m_addr_o holds s0 address throughout, s0 is granted first, then s1.
- MAX_OUTSTANDING=2: two accepts with no response -> m_req_o=0 while full. Then m_valid_i with m_error_i=1 -> error reaches the first issuer only; m_req_o reasserts the following cycle.
- m_valid_i pulse with no outstanding transaction -> no sN_valid_o and spurious_o=1 until rst_ni is asserted low. Asserting rst_ni with 2 outstanding -> count 0, rr pointer on port 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Merges an instruction request port (s0, read-only) and a data
//            request port (s1) onto one req/gnt/valid memory port. Requests
//            are arbitrated round-robin or with fixed data-port priority.
//            Up to MAX_OUTSTANDING granted transactions are tracked in a
//            1-bit ID FIFO so in-order responses reach the port that issued
//            them.
// Ports    : clk_i, rst_ni          clock, synchronous active-low reset
//            s0_*                   instruction requester (req/addr in,
//                                   gnt/valid/rdata/error out)
//            s1_*                   data requester (adds we/wdata/be)
//            m_*                    merged downstream port
//            spurious_o             sticky: response seen with nothing
//                                   outstanding
// Revision : 1.0  initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          FIXED_PRIO      = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // instruction port
  input  logic                    s0_req_i,
  input  logic [ADDR_WIDTH-1:0]   s0_addr_i,
  output logic                    s0_gnt_o,
  output logic                    s0_valid_o,
  output logic [DATA_WIDTH-1:0]   s0_rdata_o,
  output logic                    s0_error_o,
  // data port
  input  logic                    s1_req_i,
  input  logic [ADDR_WIDTH-1:0]   s1_addr_i,
  input  logic                    s1_we_i,
  input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s1_be_i,
  output logic                    s1_gnt_o,
  output logic                    s1_valid_o,
  output logic [DATA_WIDTH-1:0]   s1_rdata_o,
  output logic                    s1_error_o,
  // merged port
  output logic                    m_req_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  input  logic                    m_gnt_i,
  input  logic                    m_valid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_error_i,
  output logic                    spurious_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  // ID FIFO: each entry records which port issued the transaction
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  // stalled-request lock and arbitration state
  logic                       lock_q, lock_d;
  logic                       locked_id_q, locked_id_d;
  logic                       rr_q, rr_d;       // port favoured on a tie
  logic                       spurious_q, spurious_d;

  logic any_req, full, empty, sel, accept, pop, head;

  // Pointer increment that wraps at MAX_OUTSTANDING even when it is not a
  // power of two in the pointer width (e.g. MAX_OUTSTANDING = 1).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    any_req = s0_req_i | s1_req_i;
    full    = (count_q == MAX_CNT);
    empty   = (count_q == '0);
    m_req_o = any_req & ~full;

    // A stalled request keeps its port until accepted.
    if (lock_q) begin
      sel = locked_id_q;
    end else if (s0_req_i && s1_req_i) begin
      sel = FIXED_PRIO ? 1'b1 : rr_q;
    end else begin
      sel = s1_req_i;
    end

    accept = m_req_o & m_gnt_i;
    pop    = m_valid_i & ~empty;
    head   = fifo_q[rd_ptr_q];

    // Payload is driven only while a request is presented; port 0 is
    // read-only so its write fields are forced to zero.
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_wdata_o = '0;
    m_be_o    = '0;
    if (m_req_o) begin
      m_addr_o = sel ? s1_addr_i : s0_addr_i;
      if (sel) begin
        m_we_o    = s1_we_i;
        m_wdata_o = s1_wdata_i;
        m_be_o    = s1_be_i;
      end
    end

    s0_gnt_o   = accept & ~sel;
    s1_gnt_o   = accept &  sel;
    s0_valid_o = pop & ~head;
    s1_valid_o = pop &  head;
    s0_error_o = pop & ~head & m_error_i;
    s1_error_o = pop &  head & m_error_i;
    s0_rdata_o = pop ? m_rdata_i : '0;
    s1_rdata_o = pop ? m_rdata_i : '0;
    spurious_o = spurious_q;
  end

  // Next-state logic
  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    rr_d        = rr_q;
    spurious_d  = spurious_q | (m_valid_i & empty);

    if (accept) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_d             = ~sel;
      lock_d           = 1'b0;
    end else if (m_req_o) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      rr_q        <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      rr_q        <= rr_d;
      spurious_q  <= spurious_d;
    end
  end

endmodule
`default_nettype wire
